// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with programmable high time and period tick.
// Ratio/high-time changes are staged in pending registers and applied only at period boundaries.
module clk_divider_prog #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2,
    parameter int DEF_HI  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] hi_in,
    output logic             load_ack,
    output logic             load_err,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur
);

    localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_HI_V  = CNT_W'(DEF_HI);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_cur_reg, div_cur_next;
    logic [CNT_W-1:0] hi_cur_reg, hi_cur_next;
    logic [CNT_W-1:0] pend_div_reg, pend_div_next;
    logic [CNT_W-1:0] pend_hi_reg, pend_hi_next;
    logic             pend_reg, pend_next;
    logic             run_reg, run_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;
    logic             load_ack_reg, load_ack_next;
    logic             load_err_reg, load_err_next;

    logic             load_ok;
    logic             at_last;
    logic             apply;

    always_comb begin
        load_ok = load && (div_in >= TWO);
        at_last = (cnt_reg == div_cur_reg - ONE);
        apply   = pend_reg && (!run_reg || at_last);

        div_cur_next = apply ? pend_div_reg : div_cur_reg;
        hi_cur_next  = apply ? pend_hi_reg  : hi_cur_reg;

        // A new request always becomes pending, even on the edge that applies the old one.
        pend_next     = load_ok ? 1'b1 : (apply ? 1'b0 : pend_reg);
        pend_div_next = load_ok ? div_in : pend_div_reg;
        pend_hi_next  = pend_hi_reg;
        if (load_ok) begin
            if (hi_in == '0 || hi_in >= div_in)
                pend_hi_next = div_in >> 1;
            else
                pend_hi_next = hi_in;
        end

        load_ack_next = load_ok;
        load_err_next = load && !load_ok;

        // The wrap is decided by the period that is ending; a ratio applied on the
        // same edge then governs the fresh period starting at zero.
        run_next = 1'b0;
        cnt_next = '0;
        if (en) begin
            run_next = 1'b1;
            if (run_reg && !at_last)
                cnt_next = cnt_reg + ONE;
        end

        clk_out_next = run_next && (cnt_next < hi_cur_next);
        tick_next    = run_next && (cnt_next == div_cur_next - ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            run_reg      <= 1'b0;
            clk_out_reg  <= 1'b0;
            tick_reg     <= 1'b0;
            load_ack_reg <= 1'b0;
            load_err_reg <= 1'b0;
            pend_reg     <= 1'b0;
            pend_div_reg <= DEF_DIV_V;
            pend_hi_reg  <= DEF_HI_V;
            div_cur_reg  <= DEF_DIV_V;
            hi_cur_reg   <= DEF_HI_V;
        end else begin
            cnt_reg      <= cnt_next;
            run_reg      <= run_next;
            clk_out_reg  <= clk_out_next;
            tick_reg     <= tick_next;
            load_ack_reg <= load_ack_next;
            load_err_reg <= load_err_next;
            pend_reg     <= pend_next;
            pend_div_reg <= pend_div_next;
            pend_hi_reg  <= pend_hi_next;
            div_cur_reg  <= div_cur_next;
            hi_cur_reg   <= hi_cur_next;
        end
    end

    assign clk_out  = clk_out_reg;
    assign tick     = tick_reg;
    assign load_ack = load_ack_reg;
    assign load_err = load_err_reg;
    assign div_cur  = div_cur_reg;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog: a literal vector table, hand sequences for boundary cases,
// and random stimulus against a period-start/elapsed-time reference model.
module tb_clk_divider_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] div_in = '0;
    logic [7:0] hi_in = '0;
    logic       load_ack, load_err, clk_out, tick;
    logic [7:0] div_cur;

    int tests = 0;
    int fails = 0;

    clk_divider_prog #(.CNT_W(8), .DEF_DIV(2), .DEF_HI(1)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .div_in(div_in), .hi_in(hi_in),
        .load_ack(load_ack), .load_err(load_err), .clk_out(clk_out), .tick(tick),
        .div_cur(div_cur)
    );

    always #5 clk = ~clk;

    // Reference model: the waveform is a function of time elapsed since the current period began.
    int cyc = 0;
    int m_start = 0;
    bit m_run = 0;
    int m_n = 2;
    int m_h = 1;
    int pq_n[$];
    int pq_h[$];
    bit m_ack = 0;
    bit m_err = 0;

    function automatic void model_step(input bit r, input bit e, input bit l, input int d, input int h);
        bit boundary;
        cyc++;
        if (r) begin
            m_run = 0; m_n = 2; m_h = 1; m_ack = 0; m_err = 0;
            pq_n.delete(); pq_h.delete();
            return;
        end
        boundary = m_run && ((cyc - 1 - m_start) == m_n - 1);
        if (pq_n.size() > 0 && (!m_run || boundary)) begin
            m_n = pq_n.pop_front();
            m_h = pq_h.pop_front();
        end
        m_ack = 0; m_err = 0;
        if (l) begin
            if (d < 2) m_err = 1;
            else begin
                pq_n.delete(); pq_h.delete();
                pq_n.push_back(d);
                pq_h.push_back((h == 0 || h >= d) ? d / 2 : h);
                m_ack = 1;
            end
        end
        if (e) begin
            if (!m_run || boundary) m_start = cyc;
            m_run = 1;
        end else m_run = 0;
    endfunction

    function automatic bit exp_clk();
        return m_run && ((cyc - m_start) < m_h);
    endfunction

    function automatic bit exp_tick();
        return m_run && ((cyc - m_start) == m_n - 1);
    endfunction

    task automatic drive(input bit r, input bit e, input bit l, input int d, input int h);
        @(negedge clk);
        rst = r; en = e; load = l; div_in = 8'(d); hi_in = 8'(h);
        @(posedge clk);
        model_step(r, e, l, d, h);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit ok;
        tests++;
        ok = (clk_out == exp_clk()) && (tick == exp_tick()) && (load_ack == m_ack) &&
             (load_err == m_err) && (div_cur == 8'(m_n));
        if (!ok) begin
            fails++;
            $display("FAIL %s cyc=%0d got clk_out=%0b tick=%0b ack=%0b err=%0b div=%0d required %0b %0b %0b %0b %0d",
                     tag, cyc, clk_out, tick, load_ack, load_err, div_cur,
                     exp_clk(), exp_tick(), m_ack, m_err, m_n);
        end
    endtask

    task automatic check1(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    typedef struct {
        bit r, e, l;
        int d, h;
        bit x_clk, x_tick, x_ack, x_err;
        int x_div;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit e, input bit l, input int d, input int h,
                                input bit c, input bit t, input bit a, input bit er, input int dv);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.d = d; v.h = h;
        v.x_clk = c; v.x_tick = t; v.x_ack = a; v.x_err = er; v.x_div = dv;
        return v;
    endfunction

    vec_t vecs[24];

    initial begin
        //             r  e  l  div hi   clk tick ack err div
        vecs[0]  = mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 2);
        vecs[1]  = mk(0, 1, 0, 0, 0,    1, 0, 0, 0, 2);
        vecs[2]  = mk(0, 1, 0, 0, 0,    0, 1, 0, 0, 2);
        vecs[3]  = mk(0, 1, 0, 0, 0,    1, 0, 0, 0, 2);
        vecs[4]  = mk(0, 1, 0, 0, 0,    0, 1, 0, 0, 2);
        vecs[5]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 2);
        vecs[6]  = mk(0, 0, 1, 5, 2,    0, 0, 1, 0, 2);
        vecs[7]  = mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 5);
        vecs[8]  = mk(0, 1, 0, 0, 0,    1, 0, 0, 0, 5);
        vecs[9]  = mk(0, 1, 0, 0, 0,    1, 0, 0, 0, 5);
        vecs[10] = mk(0, 1, 0, 0, 0,    0, 0, 0, 0, 5);
        vecs[11] = mk(0, 1, 0, 0, 0,    0, 0, 0, 0, 5);
        vecs[12] = mk(0, 1, 0, 0, 0,    0, 1, 0, 0, 5);
        vecs[13] = mk(0, 1, 0, 0, 0,    1, 0, 0, 0, 5);
        vecs[14] = mk(0, 1, 1, 1, 0,    1, 0, 0, 1, 5);
        vecs[15] = mk(0, 1, 1, 6, 9,    0, 0, 1, 0, 5);
        vecs[16] = mk(0, 1, 0, 0, 0,    0, 0, 0, 0, 5);
        vecs[17] = mk(0, 1, 0, 0, 0,    0, 1, 0, 0, 5);
        vecs[18] = mk(0, 1, 0, 0, 0,    1, 0, 0, 0, 6);
        vecs[19] = mk(0, 1, 0, 0, 0,    1, 0, 0, 0, 6);
        vecs[20] = mk(0, 1, 0, 0, 0,    1, 0, 0, 0, 6);
        vecs[21] = mk(0, 1, 0, 0, 0,    0, 0, 0, 0, 6);
        vecs[22] = mk(0, 1, 0, 0, 0,    0, 0, 0, 0, 6);
        vecs[23] = mk(0, 1, 0, 0, 0,    0, 1, 0, 0, 6);

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].d, vecs[i].h);
            tests++;
            if (clk_out !== vecs[i].x_clk || tick !== vecs[i].x_tick || load_ack !== vecs[i].x_ack ||
                load_err !== vecs[i].x_err || div_cur !== 8'(vecs[i].x_div)) begin
                fails++;
                $display("FAIL vec%0d got clk_out=%0b tick=%0b ack=%0b err=%0b div=%0d required %0b %0b %0b %0b %0d",
                         i, clk_out, tick, load_ack, load_err, div_cur, vecs[i].x_clk,
                         vecs[i].x_tick, vecs[i].x_ack, vecs[i].x_err, vecs[i].x_div);
            end
        end

        // Ratio change requested mid-period waits for the boundary.
        drive(1, 0, 0, 0, 0);
        check_model("seq3_rst");
        drive(0, 0, 1, 5, 2);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 3, 1);
        check1("seq3_ack", int'(load_ack), 1);
        check1("seq3_div_hold", int'(div_cur), 5);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        check1("seq3_last_tick", int'(tick), 1);
        check1("seq3_div_before_edge", int'(div_cur), 5);
        drive(0, 1, 0, 0, 0);
        check1("seq3_div_after_edge", int'(div_cur), 3);
        check1("seq3_new_high", int'(clk_out), 1);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 0, 0);
            check_model("seq3_run");
        end

        // en dropped mid-period, then restarted fresh.
        drive(0, 1, 1, 5, 2);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
        while (!tick && cyc < 200) drive(0, 1, 0, 0, 0);
        check1("seq5_sync_tick", int'(tick), 1);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        check_model("seq5_cnt2");
        drive(0, 0, 0, 0, 0);
        check1("seq5_stop_clk", int'(clk_out), 0);
        check1("seq5_stop_tick", int'(tick), 0);
        drive(0, 1, 0, 0, 0);
        check1("seq5_restart_high", int'(clk_out), 1);
        check_model("seq5_restart");

        // Reset with a load pending discards it.
        drive(0, 1, 1, 7, 3);
        check1("seq6_ack", int'(load_ack), 1);
        drive(1, 1, 1, 9, 4);
        check1("seq6_rst_clk", int'(clk_out), 0);
        check1("seq6_rst_ack", int'(load_ack), 0);
        check1("seq6_rst_div", int'(div_cur), 2);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check1("seq6_pend_gone", int'(div_cur), 2);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, l;
            int d, h;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 11) == 0);
            d = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 12));
            h = ($urandom_range(0, 19) == 0) ? 254 : int'($urandom_range(0, 14));
            drive(r, e, l, d, h);
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
